// File: rtl/volume_shifter.sv
// Registered power-of-two volume stage: 8-bit sample in, 16-bit scaled sample out.
// The applied gain (cur_vol) ramps one code at a time toward the requested volume.
module volume_shifter #(
    parameter bit          RAMP_EN  = 1'b1,
    parameter int unsigned RAMP_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  audio_in,
    input  logic [3:0]  volume,
    input  logic        enable_volume,
    output logic [15:0] audio_out
);

    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(RAMP_DIV - 1);

    logic [3:0]       cur_vol;
    logic [3:0]       cur_vol_nxt;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_cnt_nxt;
    logic [15:0]      full;
    logic [3:0]       shamt;
    logic [15:0]      scaled;

    // Divider is a down-counter; a step fires on terminal count, and it is parked
    // at zero while settled so the first step after a new target is immediate.
    always_comb begin
        cur_vol_nxt = cur_vol;
        div_cnt_nxt = div_cnt;
        if (!RAMP_EN) begin
            cur_vol_nxt = volume;
            div_cnt_nxt = '0;
        end else if (cur_vol == volume) begin
            div_cnt_nxt = '0;
        end else if (div_cnt == '0) begin
            cur_vol_nxt = (cur_vol < volume) ? cur_vol + 4'd1 : cur_vol - 4'd1;
            div_cnt_nxt = CNT_RELOAD;
        end else begin
            div_cnt_nxt = div_cnt - 1'b1;
        end
    end

    always_comb begin
        full   = {audio_in, 8'h00};
        shamt  = 4'd15 - cur_vol;
        scaled = enable_volume ? (full >> shamt) : full;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_vol   <= 4'd0;
            div_cnt   <= '0;
            audio_out <= 16'h0000;
        end else begin
            cur_vol   <= cur_vol_nxt;
            div_cnt   <= div_cnt_nxt;
            audio_out <= scaled;
        end
    end

endmodule

// File: tb/tb_volume_shifter.sv
// Directed bench for volume_shifter: ramped (div 1), unramped, and ramped (div 3)
// instances share one stimulus; expected outputs are hand-computed constants.
module tb_volume_shifter;

    logic        clk;
    logic        rst;
    logic [7:0]  audio_in;
    logic [3:0]  volume;
    logic        enable_volume;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] out_c;

    int n_checks = 0;
    int n_errors = 0;

    volume_shifter #(.RAMP_EN(1'b1), .RAMP_DIV(1)) u_a (
        .clk(clk), .rst(rst), .audio_in(audio_in), .volume(volume),
        .enable_volume(enable_volume), .audio_out(out_a)
    );
    volume_shifter #(.RAMP_EN(1'b0), .RAMP_DIV(1)) u_b (
        .clk(clk), .rst(rst), .audio_in(audio_in), .volume(volume),
        .enable_volume(enable_volume), .audio_out(out_b)
    );
    volume_shifter #(.RAMP_EN(1'b1), .RAMP_DIV(3)) u_c (
        .clk(clk), .rst(rst), .audio_in(audio_in), .volume(volume),
        .enable_volume(enable_volume), .audio_out(out_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // audio_in=64, volume 0 -> 6
    logic [15:0] up6_a [0:7] = '{16'd0, 16'd1, 16'd2, 16'd4, 16'd8, 16'd16, 16'd32, 16'd32};
    logic [15:0] up6_c [0:7] = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd4};
    // audio_in=255, volume 6 -> 15
    logic [15:0] up15_a [0:9] = '{16'h007F, 16'h00FF, 16'h01FE, 16'h03FC, 16'h07F8,
                                  16'h0FF0, 16'h1FE0, 16'h3FC0, 16'h7F80, 16'hFF00};
    // audio_in=255, after reset, volume 0 -> 15
    logic [15:0] rst_a [0:4] = '{16'd1, 16'd3, 16'd7, 16'd15, 16'd31};
    logic [15:0] rst_c [0:4] = '{16'd1, 16'd3, 16'd3, 16'd3, 16'd7};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        audio_in      = 8'hAA;
        volume        = 4'd15;
        enable_volume = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("reset_a", out_a, 16'h0000);
        chk("reset_b", out_b, 16'h0000);
        chk("reset_c", out_c, 16'h0000);
        repeat (2) tick();
        chk("reset_hold_a", out_a, 16'h0000);
        chk("reset_hold_curvol_a", {12'h000, u_a.cur_vol}, 16'h0000);

        // release with unity pass-through
        audio_in      = 8'd64;
        volume        = 4'd0;
        enable_volume = 1'b0;
        rst           = 1'b1;
        tick();
        chk("unity_a", out_a, 16'h4000);
        chk("unity_b", out_b, 16'h4000);
        chk("unity_c", out_c, 16'h4000);

        // ramp up to 6
        enable_volume = 1'b1;
        volume        = 4'd6;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("up6_a%0d", i), out_a, up6_a[i]);
            chk($sformatf("up6_c%0d", i), out_c, up6_c[i]);
            chk($sformatf("up6_b%0d", i), out_b, (i == 0) ? 16'd0 : 16'd32);
        end
        chk("up6_curvol_a", {12'h000, u_a.cur_vol}, 16'd6);

        // ramp up to full scale
        audio_in = 8'd255;
        volume   = 4'd15;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("up15_a%0d", i), out_a, up15_a[i]);
            if (i < 2) chk($sformatf("up15_b%0d", i), out_b, (i == 0) ? 16'h007F : 16'hFF00);
        end

        // ramp down toward 10 with an enable toggle in the middle
        volume = 4'd10;
        tick();
        chk("dn_a0", out_a, 16'hFF00);
        tick();
        chk("dn_a1", out_a, 16'h7F80);
        chk("dn_b1", out_b, 16'h07F8);
        enable_volume = 1'b0;
        tick();
        chk("dis_a0", out_a, 16'hFF00);
        chk("dis_b0", out_b, 16'hFF00);
        audio_in = 8'h5A;
        tick();
        chk("dis_a1", out_a, 16'h5A00);
        audio_in      = 8'd255;
        enable_volume = 1'b1;
        tick();
        chk("reen_a0", out_a, 16'h0FF0);
        chk("reen_b0", out_b, 16'h07F8);
        tick();
        chk("reen_a1", out_a, 16'h07F8);
        tick();
        chk("reen_a2", out_a, 16'h07F8);
        chk("reen_curvol_a", {12'h000, u_a.cur_vol}, 16'd10);

        // asynchronous reset mid-operation, between clock edges
        volume = 4'd15;
        #2 rst = 1'b0;
        #1;
        chk("midrst_a", out_a, 16'h0000);
        chk("midrst_b", out_b, 16'h0000);
        chk("midrst_curvol_a", {12'h000, u_a.cur_vol}, 16'h0000);
        chk("midrst_curvol_c", {12'h000, u_c.cur_vol}, 16'h0000);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("post_rst_a%0d", i), out_a, rst_a[i]);
            chk($sformatf("post_rst_c%0d", i), out_c, rst_c[i]);
            chk($sformatf("post_rst_b%0d", i), out_b, (i == 0) ? 16'd1 : 16'hFF00);
        end

        // unramped instance: volume 15 -> 0 -> 15
        volume = 4'd0;
        tick();
        chk("noramp_dn0", out_b, 16'hFF00);
        tick();
        chk("noramp_dn1", out_b, 16'd1);
        volume = 4'd15;
        tick();
        chk("noramp_up0", out_b, 16'd1);
        tick();
        chk("noramp_up1", out_b, 16'hFF00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
